ram_loader: RTL
===============

# ram_loader

Streaming program/data loader that sits directly upstream of the 16-bit data RAM. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and writes them to consecutive RAM addresses starting at a base address. It drives the RAM's `address`/`load`/`in` inputs, so a host can fill RAM before the CPU runs, without a CPU in the loop.

## Interface
- `BASE` — default 0 — first RAM address written (16-bit).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a transfer; ignored while `busy`=1.
- `length`  in  16  number of words to write; sampled when `start` is accepted.
- `byte_in`  in  8  incoming data byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  the loader accepts a byte this cycle.
- `ram_address`  out  16  connects to the RAM `address` input.
- `ram_in`  out  16  connects to the RAM `in` input.
- `ram_load`  out  1  connects to the RAM `load` input; RAM write enable.
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `count`  out  16  number of words written so far in the current or last transfer.

## Operation
- States: IDLE, HI, LO, WRITE, FIN.
- IDLE: `busy`=0, `byte_ready`=0.
  - On `start`: latch `length` into `len_q`, set `count`=0.
  - Go to FIN if `length`=0, otherwise go to HI.
- HI: `byte_ready`=1.
  - On `byte_valid`: latch `byte_in` as the high byte and go to LO.
  - Otherwise stay in HI; no timeout.
- LO: `byte_ready`=1.
  - On `byte_valid`: latch `byte_in` as the low byte.
  - Load `ram_in`={hi,lo} and `ram_address`=BASE+`count` (mod 2^16). Go to WRITE.
- WRITE: `ram_load`=1 for exactly this one cycle; `byte_ready`=0.
  - At the end of the cycle, `count` increments.
  - If the new `count`=`len_q`, go to FIN; otherwise go to HI.
- FIN: `done`=1 for this one cycle, `busy`=0. Go to IDLE.
- `busy`=1 in HI, LO and WRITE only.
- `start` is ignored in every state except IDLE.
- `length` changes after `start` is accepted have no effect.
- Address wrap-around: BASE+`count` overflows modulo 2^16 with no error. 0xFFFF is followed by 0x0000.
- `ram_address` and `ram_in` hold their last values outside WRITE. `ram_load`=0 outside WRITE.
- Byte order: the first byte of each pair is bits [15:8], the second is bits [7:0].
- `count` holds its final value after FIN until the next accepted `start`.

## Timing
- Reset values: state IDLE; `byte_ready`, `ram_load`, `busy`, `done` = 0; `ram_address`, `ram_in`, `count` = 0.
- A byte is transferred on a rising edge where `byte_valid`=1 and `byte_ready`=1. The source may hold `byte_valid` high continuously.
- Minimum cost is 3 cycles per word (HI, LO, WRITE).
- The RAM captures the word on the rising edge that ends the WRITE cycle. The value reads back on the RAM output the cycle after that edge.
- `start` at edge N gives `busy`=1 in cycle N+1 (or `done`=1 in N+1 when `length`=0).
- The final WRITE is followed by `done` in the next cycle; `busy` falls in that same cycle.
- Reset mid-transfer, including during WRITE:
  - Next cycle is IDLE with all outputs at reset values.
  - A WRITE cycle coinciding with reset still asserts `ram_load` in that cycle. No further writes occur.
  - Partially assembled bytes are discarded.
- `reset` and `start` asserted together: reset wins; state is IDLE.

## Test plan
- Reset, then `start` with `length`=2 and BASE=0. Send bytes 0x10, 0xE1, 0x30, 0x39. RAM[0] reads 4321 and RAM[1] reads 12345. `done` pulses once, `count`=2, and `ram_load` was high for exactly 2 cycles.
- `length`=0: `start` produces `done` in the next cycle. `ram_load` never asserts and `byte_ready` stays 0.
- Throttled source with `byte_valid` toggling every other cycle for `length`=3: all 3 words are written correctly. No byte is lost or duplicated, and no write occurs while a word is only half assembled.
- BASE=0xFFFF with `length`=2 writing 0xAAAA and 0x5555: the writes go to 0xFFFF, then 0x0000.
- A `start` pulse mid-transfer with a different `length`: it is ignored, and the original `length` is honoured.
- Assert `reset` while in LO after the high byte was accepted: the next cycle is IDLE with `busy`=0 and `count`=0. A new transfer then starts cleanly from the high byte.

Source files
------------

// File: rtl/ram_loader.sv
// Byte-stream loader for the 16-bit data RAM.
// Pairs big-endian bytes into words and writes them to BASE, BASE+1, ...
module ram_loader #(
  parameter logic [15:0] BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] length,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] ram_address,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic        busy,
  output logic        done,
  output logic [15:0] count
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   len_q, len_d;
  logic [WORD_W-1:0]   count_q, count_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [WORD_W-1:0]   ram_address_q, ram_address_d;
  logic [WORD_W-1:0]   ram_in_q, ram_in_d;
  logic                byte_ready_q, byte_ready_d;
  logic                ram_load_q, ram_load_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   count_inc;

  assign count_inc = count_q + WORD_W'(1);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      count_q       <= '0;
      hi_q          <= '0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
      byte_ready_q  <= 1'b0;
      ram_load_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      count_q       <= count_d;
      hi_q          <= hi_d;
      ram_address_q <= ram_address_d;
      ram_in_q      <= ram_in_d;
      byte_ready_q  <= byte_ready_d;
      ram_load_q    <= ram_load_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // line up with the state they describe once registered.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    count_d       = count_q;
    hi_d          = hi_q;
    ram_address_d = ram_address_q;
    ram_in_d      = ram_in_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = length;
          count_d = '0;
          state_d = (length == '0) ? S_FIN : S_HI;
        end
      end
      S_HI: begin
        if (byte_valid) begin
          hi_d    = byte_in;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (byte_valid) begin
          ram_in_d      = {hi_q, byte_in};
          ram_address_d = BASE + count_q;
          state_d       = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_inc;
        state_d = (count_inc == len_q) ? S_FIN : S_HI;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    byte_ready_d = (state_d == S_HI) || (state_d == S_LO);
    busy_d       = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_WRITE);
    ram_load_d   = (state_d == S_WRITE);
    done_d       = (state_d == S_FIN);
  end

  assign byte_ready  = byte_ready_q;
  assign ram_address = ram_address_q;
  assign ram_in      = ram_in_q;
  assign ram_load    = ram_load_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign count       = count_q;

endmodule
